// File: rtl/mdu_unit.sv
// mdu_unit: RV32M multiply/divide functional unit.
// Multiplies finish in one registered cycle; divides run a 32-step radix-2
// restoring loop. Each result leaves as a one-cycle writeback pulse tagged
// with its scoreboard index.

package mdu_pkg;

    localparam int unsigned FuIdxWidth = 3;

    typedef enum logic [2:0] {
        MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU
    } fu_op_t;

    typedef struct packed {
        fu_op_t                 operation;
        logic [31:0]            operand_a;
        logic [31:0]            operand_b;
        logic [FuIdxWidth-1:0]  idx;
    } fu_data_t;

endpackage

module mdu_unit
    import mdu_pkg::*;
#(
    parameter int unsigned IdxWidth = FuIdxWidth
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                flush,
    input  logic                mdu_valid,
    input  fu_data_t            fu_data,
    output logic                mdu_ready,
    output logic                result_valid,
    output logic [31:0]         result,
    output logic [IdxWidth-1:0] result_idx
);

    typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DIV, ST_DONE} state_t;

    state_t             state;
    fu_op_t             op_q;
    logic signed [32:0] mul_a;
    logic signed [32:0] mul_b;
    logic [31:0]        dividend;   // shifts out dividend bits, shifts in quotient bits
    logic [31:0]        divisor;
    logic [32:0]        prem;
    logic [4:0]         count;
    logic               neg_q;
    logic               neg_r;

    // accept-side decode
    fu_op_t      in_op;
    logic        accept;
    logic        in_mul;
    logic        in_div_signed;
    logic        in_quot;
    logic        in_sgn_a;
    logic        in_sgn_b;
    logic        in_div_zero;
    logic        in_overflow;
    logic [31:0] abs_a;
    logic [31:0] abs_b;
    logic [31:0] special_result;

    // datapath
    logic [33:0]        shifted;
    logic [33:0]        diff;
    logic               ge;
    logic [32:0]        prem_next;
    logic [31:0]        quot_next;
    logic [31:0]        q_fix;
    logic [31:0]        r_fix;
    logic [31:0]        div_result;
    logic signed [63:0] product;
    logic [31:0]        mul_result;

    assign mdu_ready    = (state == ST_IDLE);
    assign result_valid = (state == ST_DONE) && !flush;

    // Decode the incoming operation: operand signedness, absolute values, special divides
    always_comb begin
        in_op         = fu_data.operation;
        accept        = mdu_valid && (state == ST_IDLE) && !flush;
        in_mul        = (in_op == MUL) || (in_op == MULH) || (in_op == MULHSU) || (in_op == MULHU);
        in_div_signed = (in_op == DIV) || (in_op == REM);
        in_quot       = (in_op == DIV) || (in_op == DIVU);
        // a sign bit only counts when the operation treats that operand as signed
        in_sgn_a      = fu_data.operand_a[31] &&
                        ((in_op == MUL) || (in_op == MULH) || (in_op == MULHSU) || in_div_signed);
        in_sgn_b      = fu_data.operand_b[31] &&
                        ((in_op == MUL) || (in_op == MULH) || in_div_signed);
        abs_a         = in_sgn_a ? -fu_data.operand_a : fu_data.operand_a;
        abs_b         = in_sgn_b ? -fu_data.operand_b : fu_data.operand_b;
        in_div_zero   = (fu_data.operand_b == '0);
        in_overflow   = in_div_signed && (fu_data.operand_a == 32'h8000_0000) &&
                        (fu_data.operand_b == '1);
        if (in_div_zero) begin
            special_result = in_quot ? '1 : fu_data.operand_a;
        end else begin
            special_result = in_quot ? 32'h8000_0000 : '0;
        end
    end

    // One restoring-divide step, final sign fix, and the multiply product
    always_comb begin
        shifted    = {prem, dividend[31]};
        diff       = shifted - {2'b00, divisor};
        ge         = !diff[33];
        prem_next  = ge ? diff[32:0] : shifted[32:0];
        quot_next  = {dividend[30:0], ge};
        q_fix      = neg_q ? -quot_next : quot_next;
        r_fix      = neg_r ? -prem_next[31:0] : prem_next[31:0];
        div_result = ((op_q == DIV) || (op_q == DIVU)) ? q_fix : r_fix;
        product    = 64'(mul_a) * 64'(mul_b);
        mul_result = (op_q == MUL) ? product[31:0] : product[63:32];
    end

    // Control FSM with registered result, index and divider state
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            op_q       <= MUL;
            mul_a      <= '0;
            mul_b      <= '0;
            dividend   <= '0;
            divisor    <= '0;
            prem       <= '0;
            count      <= '0;
            neg_q      <= 1'b0;
            neg_r      <= 1'b0;
            result     <= '0;
            result_idx <= '0;
        end else if (flush) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        op_q       <= in_op;
                        result_idx <= IdxWidth'(fu_data.idx);
                        mul_a      <= {in_sgn_a, fu_data.operand_a};
                        mul_b      <= {in_sgn_b, fu_data.operand_b};
                        dividend   <= abs_a;
                        divisor    <= abs_b;
                        neg_q      <= in_sgn_a ^ in_sgn_b;
                        neg_r      <= in_sgn_a;
                        prem       <= '0;
                        count      <= '0;
                        if (in_mul) begin
                            state <= ST_MUL;
                        end else if (in_div_zero || in_overflow) begin
                            result <= special_result;
                            state  <= ST_DONE;
                        end else begin
                            state <= ST_DIV;
                        end
                    end
                end
                ST_MUL: begin
                    result <= mul_result;
                    state  <= ST_DONE;
                end
                ST_DIV: begin
                    prem     <= prem_next;
                    dividend <= quot_next;
                    count    <= count + 5'd1;
                    if (count == 5'd31) begin
                        result <= div_result;
                        state  <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_unit.sv
// Testbench for mdu_unit: directed RV32M cases, flush/reset scenarios and a
// back-to-back random stream checked against an arithmetic reference model.

module tb_mdu_unit;
    import mdu_pkg::*;

    localparam int StressOps = 30;

    logic        clock;
    logic        reset_n;
    logic        flush;
    logic        mdu_valid;
    fu_data_t    fu_data;
    logic        mdu_ready;
    logic        result_valid;
    logic [31:0] result;
    logic [2:0]  result_idx;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [31:0] r;
        logic [2:0]  idx;
        int          due;
    } exp_t;

    exp_t q[$];

    mdu_unit #(.IdxWidth(3)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .flush        (flush),
        .mdu_valid    (mdu_valid),
        .fu_data      (fu_data),
        .mdu_ready    (mdu_ready),
        .result_valid (result_valid),
        .result       (result),
        .result_idx   (result_idx)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // RV32M result computed with 64-bit integer arithmetic
    function automatic logic [31:0] ref_result(fu_op_t op, logic [31:0] a, logic [31:0] b);
        longint sa, sb, ua, ub;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'h0, a});
        ub = longint'({32'h0, b});
        p  = '0;
        case (op)
            MUL:    begin p = sa * sb; return p[31:0];  end
            MULH:   begin p = sa * sb; return p[63:32]; end
            MULHSU: begin p = sa * ub; return p[63:32]; end
            MULHU:  begin p = ua * ub; return p[63:32]; end
            DIV: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                p = sa / sb; return p[31:0];
            end
            REM: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                p = sa % sb; return p[31:0];
            end
            DIVU: begin
                if (b == 0) return 32'hFFFF_FFFF;
                p = ua / ub; return p[31:0];
            end
            default: begin
                if (b == 0) return a;
                p = ua % ub; return p[31:0];
            end
        endcase
    endfunction

    function automatic int ref_latency(fu_op_t op, logic [31:0] a, logic [31:0] b);
        if (op == MUL || op == MULH || op == MULHSU || op == MULHU) return 2;
        if (b == 0) return 1;
        if ((op == DIV || op == REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 33;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_op(input fu_op_t op, input logic [31:0] a, input logic [31:0] b,
                          input logic [2:0] idx);
        fu_data.operation = op;
        fu_data.operand_a = a;
        fu_data.operand_b = b;
        fu_data.idx       = idx;
    endtask

    // Issue one operation and watch 40 cycles: value, index, latency, pulse width, ready window
    task automatic run_op(input string tag, input fu_op_t op, input logic [31:0] a,
                          input logic [31:0] b, input logic [2:0] idx, input logic [31:0] exp);
        int lat, nvalid, explat;
        logic ready_ok;
        logic [31:0] res;
        logic [2:0] ridx;
        explat = ref_latency(op, a, b);
        lat = 0; nvalid = 0; ready_ok = 1'b1; res = '0; ridx = '0;
        @(negedge clock);
        check({tag, "_ready_before"}, 64'(mdu_ready), 64'd1);
        set_op(op, a, b, idx);
        mdu_valid = 1'b1;
        @(posedge clock);
        #1 mdu_valid = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clock);
            if (result_valid) begin
                if (nvalid == 0) begin
                    lat  = k;
                    res  = result;
                    ridx = result_idx;
                end
                nvalid++;
            end
            if (k <= explat && mdu_ready) ready_ok = 1'b0;
            if (k == explat + 1 && !mdu_ready) ready_ok = 1'b0;
        end
        check({tag, "_result"}, 64'(res), 64'(exp));
        check({tag, "_idx"}, 64'(ridx), 64'(idx));
        check({tag, "_latency"}, 64'(lat), 64'(explat));
        check({tag, "_pulses"}, 64'(nvalid), 64'd1);
        check({tag, "_ready_window"}, 64'(ready_ok), 64'd1);
    endtask

    task automatic rand_op();
        fu_op_t op;
        logic [31:0] a, b;
        op = fu_op_t'($urandom_range(0, 7));
        a  = $urandom;
        b  = $urandom;
        case ($urandom_range(0, 9))
            0: b = '0;
            1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            2: b = $urandom_range(1, 15);
            default: ;
        endcase
        set_op(op, a, b, 3'($urandom_range(0, 7)));
    endtask

    initial begin
        int nvalid, n_acc, n_wb, viol;
        logic rdy, prev_idle;
        exp_t e;

        reset_n = 1'b0; flush = 1'b0; mdu_valid = 1'b0; fu_data = '0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("reset_ready", 64'(mdu_ready), 64'd1);
        check("reset_valid", 64'(result_valid), 64'd0);
        check("reset_result", 64'(result), 64'd0);
        check("reset_idx", 64'(result_idx), 64'd0);
        @(posedge clock);
        #1 reset_n = 1'b1;

        // multiply variants
        run_op("mul",    MUL,    32'hFFFF_FFFD, 32'd7,         3'd1, 32'hFFFF_FFEB);
        run_op("mulh",   MULH,   32'hFFFF_FFFD, 32'd7,         3'd2, 32'hFFFF_FFFF);
        run_op("mulhu",  MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'd3, 32'hFFFF_FFFE);
        run_op("mulhsu", MULHSU, 32'hFFFF_FFFF, 32'd2,         3'd4, 32'hFFFF_FFFF);

        // iterative divides
        run_op("div",  DIV,  32'hFFFF_FFF9, 32'd2, 3'd5, 32'hFFFF_FFFD);
        run_op("rem",  REM,  32'hFFFF_FFF9, 32'd2, 3'd6, 32'hFFFF_FFFF);
        run_op("divu", DIVU, 32'd100,       32'd7, 3'd7, 32'd14);
        run_op("remu", REMU, 32'd100,       32'd7, 3'd0, 32'd2);
        run_op("div_neg_b", DIV, 32'd1000, 32'hFFFF_FFFD, 3'd2,
               ref_result(DIV, 32'd1000, 32'hFFFF_FFFD));

        // special-case divides
        run_op("divu_by0",   DIVU, 32'd5,         32'd0,         3'd1, 32'hFFFF_FFFF);
        run_op("rem_by0",    REM,  32'd5,         32'd0,         3'd2, 32'd5);
        run_op("div_ovf",    DIV,  32'h8000_0000, 32'hFFFF_FFFF, 3'd3, 32'h8000_0000);
        run_op("rem_ovf",    REM,  32'h8000_0000, 32'hFFFF_FFFF, 3'd4, 32'd0);

        // flush and valid together in IDLE: nothing accepted
        @(negedge clock);
        set_op(MUL, 32'd3, 32'd3, 3'd5);
        mdu_valid = 1'b1; flush = 1'b1;
        @(posedge clock);
        #1 mdu_valid = 1'b0; flush = 1'b0;
        nvalid = 0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clock);
            if (result_valid || !mdu_ready) nvalid++;
        end
        check("flush_vs_valid_idle", 64'(nvalid), 64'd0);

        // flush mid-divide
        @(negedge clock);
        set_op(DIVU, 32'd1000, 32'd3, 3'd6);
        mdu_valid = 1'b1;
        @(posedge clock);
        #1 mdu_valid = 1'b0;
        nvalid = 0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clock);
            if (result_valid) nvalid++;
        end
        flush = 1'b1;
        @(posedge clock);
        #1 flush = 1'b0;
        @(negedge clock);
        check("flush_div_ready", 64'(mdu_ready), 64'd1);
        for (int k = 1; k <= 40; k++) begin
            @(negedge clock);
            if (result_valid) nvalid++;
        end
        check("flush_div_no_wb", 64'(nvalid), 64'd0);
        run_op("mul_after_flush", MUL, 32'd6, 32'd7, 3'd7, 32'd42);

        // flush during DONE
        @(negedge clock);
        set_op(MUL, 32'd9, 32'd9, 3'd3);
        mdu_valid = 1'b1;
        @(posedge clock);
        #1 mdu_valid = 1'b0;
        @(negedge clock);
        @(negedge clock);
        check("done_valid_before_flush", 64'(result_valid), 64'd1);
        flush = 1'b1;
        #1 check("done_valid_flushed", 64'(result_valid), 64'd0);
        @(posedge clock);
        #1 flush = 1'b0;
        @(negedge clock);
        check("done_flush_ready", 64'(mdu_ready), 64'd1);
        check("done_flush_valid", 64'(result_valid), 64'd0);

        // reset mid-divide
        @(negedge clock);
        set_op(DIV, 32'h7000_0000, 32'd3, 3'd5);
        mdu_valid = 1'b1;
        @(posedge clock);
        #1 mdu_valid = 1'b0;
        repeat (21) @(negedge clock);
        reset_n = 1'b0;
        @(posedge clock);
        #1 reset_n = 1'b1;
        @(negedge clock);
        check("rst_mid_ready", 64'(mdu_ready), 64'd1);
        check("rst_mid_valid", 64'(result_valid), 64'd0);
        check("rst_mid_result", 64'(result), 64'd0);
        check("rst_mid_idx", 64'(result_idx), 64'd0);
        nvalid = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clock);
            if (result_valid) nvalid++;
        end
        check("rst_mid_no_wb", 64'(nvalid), 64'd0);

        // back-to-back stream with mdu_valid held high
        n_acc = 0; n_wb = 0; viol = 0; prev_idle = 1'b0;
        @(negedge clock);
        rand_op();
        mdu_valid = 1'b1;
        for (int cyc = 0; cyc < 3000 && n_wb < StressOps; cyc++) begin
            if (cyc > 0) @(negedge clock);
            if (result_valid) begin
                if (q.size() == 0) begin
                    check("stress_spurious_wb", 64'd1, 64'd0);
                end else begin
                    e = q.pop_front();
                    check("stress_result", 64'(result), 64'(e.r));
                    check("stress_idx", 64'(result_idx), 64'(e.idx));
                    check("stress_latency", 64'(cyc), 64'(e.due));
                    n_wb++;
                end
            end
            rdy = mdu_ready;
            if (prev_idle && rdy) viol++;
            prev_idle = rdy && mdu_valid;
            @(posedge clock);
            if (rdy && mdu_valid) begin
                e.r   = ref_result(fu_data.operation, fu_data.operand_a, fu_data.operand_b);
                e.idx = fu_data.idx;
                e.due = cyc + ref_latency(fu_data.operation, fu_data.operand_a, fu_data.operand_b);
                q.push_back(e);
                n_acc++;
            end
            #1;
            if (n_acc >= StressOps) mdu_valid = 1'b0;
            else rand_op();
        end
        mdu_valid = 1'b0;
        check("stress_writebacks", 64'(n_wb), 64'(StressOps));
        check("stress_one_accept_per_idle", 64'(viol), 64'd0);
        check("stress_queue_empty", 64'(q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
